// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: credit-limited word requests to imem, in-order response FIFO,
// and PC redirect with flush of wrong-path responses that are still in flight.
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0004,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  next_pc_sel,
    input  logic [31:0] jump_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW = CW + 4;

    logic          r_run;
    logic          r_pend;
    logic          r_wp;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_tgt;
    logic [31:0]   r_resp_pc;
    logic [OW-1:0] r_out;
    logic [OW-1:0] r_discard;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
    logic [31:0]   r_fifo_data [FIFO_DEPTH];

    logic          w_redir;
    logic          w_grant;
    logic          w_rv;
    logic          w_push;
    logic          w_pop;
    logic          w_credit;
    logic [31:0]   w_target;
    logic [OW-1:0] w_live;
    logic [OW-1:0] w_out_n;

    assign inst_valid = (r_count != '0);
    assign inst       = r_fifo_data[r_rptr];
    assign inst_pc    = r_fifo_pc[r_rptr];

    // Live slots = buffered + correct-path in flight; a pop this cycle frees its slot in time.
    always_comb begin
        w_redir   = (next_pc_sel != 2'b00);
        w_target  = next_pc_sel[1] ? TRAP_VECTOR : (jump_addr & ~32'd3);
        w_pop     = inst_valid && inst_ready;
        w_live    = OW'(r_count) + r_out - r_discard;
        w_credit  = (w_live - OW'(w_pop)) < OW'(FIFO_DEPTH);
        imem_req  = r_run && (r_pend || w_credit);
        imem_addr = r_fetch_pc;
        w_grant   = imem_req && imem_gnt;
        w_rv      = imem_rvalid && (r_out != '0);
        w_push    = w_rv && !w_redir && (r_discard == '0);
        w_out_n   = r_out + OW'(w_grant) - OW'(w_rv);
    end

    // Request side; a held request keeps its address and is charged to discard when granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_pend     <= 1'b0;
            r_wp       <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_tgt      <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_out      <= '0;
            r_discard  <= '0;
        end else begin
            r_run  <= 1'b1;
            r_pend <= imem_req && !imem_gnt;
            r_out  <= w_out_n;
            if (w_redir) begin
                r_discard <= w_out_n;
                r_resp_pc <= w_target;
                if (imem_req && !imem_gnt) begin
                    r_tgt <= w_target;
                    r_wp  <= 1'b1;
                end else begin
                    r_fetch_pc <= w_target;
                    r_wp       <= 1'b0;
                end
            end else begin
                r_discard <= r_discard - OW'(w_rv && (r_discard != '0)) + OW'(w_grant && r_wp);
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (w_grant) begin
                    r_fetch_pc <= r_wp ? r_tgt : r_fetch_pc + 32'd4;
                    r_wp       <= 1'b0;
                end
            end
        end
    end

    // Instruction buffer; a redirect empties it on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_fifo_pc[i]   <= '0;
                r_fifo_data[i] <= '0;
            end
        end else if (w_redir) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_pc[r_wptr]   <= r_resp_pc;
                r_fifo_data[r_wptr] <= imem_rdata;
                r_wptr              <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule
